// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   - state_t: FSM states of muldiv_unit
//   - OP_*   : op_mul_i / op_div_i encodings from the decoder
//   - DIV_ZERO_Q, INT_MIN: divide special-case constants
//   - neg_if : conditional two's-complement negate
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    // op_mul_i encodings
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // op_div_i encodings: bit 0 = unsigned, bit 1 = remainder
    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic [31:0] neg_if(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem          in  32 : partial remainder (always < divisor)
//   dividend_bit in  1  : next dividend bit shifted in at the LSB
//   divisor      in  32 : divisor magnitude
//   rem_next     out 32 : partial remainder after this step
//   q_bit        out 1  : quotient bit produced by this step
module div_step (
    input  logic [31:0] rem,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};

    // No borrow out of the trial subtraction means shifted >= divisor.
    assign q_bit    = ~diff[32];
    // The restored or reduced remainder stays below the divisor, so 32 bits suffice.
    assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) for the EX stage.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   start_i            : start request, sampled only in IDLE
//   sel_i              : 0 = multiply, 1 = divide
//   op_mul_i, op_div_i : operation select
//   rs1_i, rs2_i       : operands (dividend/multiplicand, divisor/multiplier)
//   flush_i            : abort the in-flight operation
//   busy_o             : high while iterating (states MUL and DIV)
//   done_o             : one-cycle pulse, result_o valid in that cycle
//   result_o           : result register, held until the next done_o
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            sel_i,
    input  logic [1:0]      op_mul_i,
    input  logic [1:0]      op_div_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_t      state;
    logic [4:0]  cnt;
    logic        sel_q;
    logic [1:0]  op_q;
    logic        neg_q;     // product / quotient sign
    logic        neg_r;     // remainder sign
    logic [31:0] opa;       // multiplicand, or dividend shifting into quotient
    logic [31:0] opb;       // multiplier shifting out, or divisor
    logic [31:0] hi;        // product high half, or partial remainder

    // ---------------- accept-time decode ----------------
    logic        accept;
    logic        rs1_neg, rs2_neg;
    logic        div_special;
    logic [31:0] special_res;

    assign accept  = (state == IDLE) && start_i && !flush_i;
    assign rs1_neg = rs1_i[31] & (sel_i ? ~op_div_i[0] : (op_mul_i != OP_MULHU));
    assign rs2_neg = rs2_i[31] & (sel_i ? ~op_div_i[0] : ~op_mul_i[1]);

    assign div_special = (rs2_i == '0) ||
                         (!op_div_i[0] && rs1_i == INT_MIN && rs2_i == 32'hFFFF_FFFF);
    assign special_res = (rs2_i == '0) ? (op_div_i[1] ? rs1_i : DIV_ZERO_Q)
                                       : (op_div_i[1] ? 32'd0 : INT_MIN);

    // ---------------- divide datapath ----------------
    logic [31:0] div_rem_next;
    logic        div_q;
    logic [31:0] div_res;

    div_step u_div_step (
        .rem          (hi),
        .dividend_bit (opa[31]),
        .divisor      (opb),
        .rem_next     (div_rem_next),
        .q_bit        (div_q)
    );

    assign div_res = op_q[1] ? neg_if(div_rem_next, neg_r)
                             : neg_if({opa[30:0], div_q}, neg_q);

    // ---------------- multiply datapath ----------------
    logic [31:0] iter_res;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended 33-bit operands; the low 64 bits of their product are exact.
    logic signed [63:0] fast_a, fast_b;
    logic [63:0]        fast_prod;
    logic [31:0]        fast_res;

    assign fast_a    = {{32{rs1_neg}}, rs1_i};
    assign fast_b    = {{32{rs2_neg}}, rs2_i};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (op_mul_i == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`else
    // Shift-add: {hi, opb} shifts right each cycle; opb[0] is the current multiplier bit.
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_next, mul_lo_next;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign mul_sum     = {1'b0, hi} + (opb[0] ? {1'b0, opa} : 33'd0);
    assign mul_hi_next = mul_sum[32:1];
    assign mul_lo_next = {mul_sum[0], opb[31:1]};
    assign prod        = neg_q ? (~{mul_hi_next, mul_lo_next} + 64'd1)
                               : {mul_hi_next, mul_lo_next};
    assign mul_res     = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        iter_res = div_res;
`ifndef MULDIV_FAST_MUL_EN
        if (!sel_q) iter_res = mul_res;
`endif
    end

    assign busy_o = (state == MUL) || (state == DIV);

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            sel_q    <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        cnt   <= '0;
                        sel_q <= sel_i;
                        op_q  <= sel_i ? op_div_i : op_mul_i;
                        neg_q <= rs1_neg ^ rs2_neg;
                        neg_r <= rs1_neg;
                        if (sel_i) begin
                            if (div_special) begin
                                state    <= DONE;
                                done_o   <= 1'b1;
                                result_o <= special_res;
                            end else begin
                                state <= DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= fast_res;
`else
                            state <= MUL;
`endif
                        end
                    end
                    MUL, DIV: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= iter_res;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: datapath registers are not reset; they are always loaded on accept before being used.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            opa <= neg_if(rs1_i, rs1_neg);
            opb <= neg_if(rs2_i, rs2_neg);
            hi  <= '0;
`ifndef MULDIV_FAST_MUL_EN
        end else if (state == MUL) begin
            hi  <= mul_hi_next;
            opb <= mul_lo_next;
`endif
        end else if (state == DIV) begin
            hi  <= div_rem_next;
            opa <= {opa[30:0], div_q};
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector scoreboard bench for muldiv_unit.
// Stimulus pushes the hand-computed result, latency and busy-run length;
// a monitor pops and compares on every done_o pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_N = 1;
    localparam int MUL_B = 0;
`else
    localparam int MUL_N = 33;
    localparam int MUL_B = 32;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        sel_i = 1'b0;
    logic [1:0]  op_mul_i = '0;
    logic [1:0]  op_div_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .sel_i    (sel_i),
        .op_mul_i (op_mul_i),
        .op_div_i (op_div_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          busy;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          busy_run = 0;
    int          done_seen = 0;
    int          pushed = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk_i) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every done_o pulse against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (done_o) begin
            done_seen++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got result %h expected no done_o", result_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result_o, mon_e.res);
                check({mon_e.name, "_latency"}, 32'(cycle - mon_e.t0), 32'(mon_e.lat));
                check({mon_e.name, "_busy_cycles"}, 32'(busy_run), 32'(mon_e.busy));
            end
        end
        if (busy_o) busy_run++;
        else        busy_run = 0;
    end

    // Drive a start at the current negedge (DUT in IDLE), push the expectation,
    // and release start at the next negedge.
    task automatic issue(input string name, input logic sel, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int busy);
        start_i  = 1'b1;
        sel_i    = sel;
        op_mul_i = op;
        op_div_i = op;
        rs1_i    = a;
        rs2_i    = b;
        sb.push_back(exp_t'{name, exp, lat, busy, cycle});
        pushed++;
        last_exp = exp;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            if (sb.size() == 0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got no done_o in 100 cycles expected one", name);
        sb.delete();
    endtask

    task automatic run(input string name, input logic sel, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int busy);
        @(negedge clk_i);
        issue(name, sel, op, a, b, exp, lat, busy);
        wait_done(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk_i);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        rst_ni = 1'b1;

        // Multiply
        run("mul",    1'b0, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_N, MUL_B);
        run("mulhu",  1'b0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_N, MUL_B);
        run("mulhsu", 1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_N, MUL_B);
        run("mulh",   1'b0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_N, MUL_B);

        // Iterative divide
        run("div",    1'b1, OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        run("rem",    1'b1, OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        run("divu",   1'b1, OP_DIVU, 32'd100,       32'd7, 32'd14,        33, 32);
        run("remu",   1'b1, OP_REMU, 32'd100,       32'd7, 32'd2,         33, 32);
        run("div_nn", 1'b1, OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 32);
        run("rem_nn", 1'b1, OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 32);
        run("divu_min", 1'b1, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 32);

        // Special-case divide
        run("divu_zero", 1'b1, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run("rem_zero",  1'b1, OP_REM,  32'd5, 32'd0, 32'd5,         1, 0);
        run("remu_zero", 1'b1, OP_REMU, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
        run("div_ovf",   1'b1, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run("rem_ovf",   1'b1, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Flush at cycle 10 of a DIV, then restart on the following cycle
        @(negedge clk_i);
        start_i = 1'b1; sel_i = 1'b1; op_div_i = OP_DIV;
        rs1_i = 32'd1000; rs2_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_result_hold", result_o, last_exp);
        issue("after_flush", 1'b1, OP_REMU, 32'd100, 32'd7, 32'd2, 33, 32);
        wait_done("after_flush");

        // start toggled while a MUL is busy
        @(negedge clk_i);
        issue("mul_busy", 1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_N, MUL_B);
        sel_i = 1'b1; op_div_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            start_i = ~start_i;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        wait_done("mul_busy");

        // start with flush in the same cycle: nothing accepted
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; sel_i = 1'b1; op_div_i = OP_DIVU;
        rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        check("start_flush_busy", 32'(busy_o), 32'd0);
        check("start_flush_done", 32'(done_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("start_flush_idle_busy", 32'(busy_o), 32'd0);

        // Reset at cycle 5 of a DIV
        start_i = 1'b1; sel_i = 1'b1; op_div_i = OP_DIVU;
        rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midreset_busy", 32'(busy_o), 32'd0);
        check("midreset_done", 32'(done_o), 32'd0);
        check("midreset_result", result_o, 32'd0);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);

        check("done_pulse_count", 32'(done_seen), 32'(pushed));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
